// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Holds the FSM state type and the divide-by-zero quotient fill value.
package divu_pkg;

  localparam int unsigned MaxWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDz   = 2'd2
  } state_e;

  // Quotient reported on divide-by-zero: all ones in the low w bits.
  function automatic logic [MaxWidth-1:0] dz_fill(input int unsigned w);
    logic [31:0] ones;
    ones = (32'd1 << w) - 32'd1;
    return ones[MaxWidth-1:0];
  endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits. The compare uses WIDTH+1 bits.
module divu_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH:0] t;
  logic           ge;

  always_comb begin
    t  = {p_i, a_i[WIDTH-1]};
    ge = (t >= {1'b0, d_i});
    // When ge, the difference is below D so the low WIDTH bits are exact.
    p_o = ge ? (t[WIDTH-1:0] - d_i) : t[WIDTH-1:0];
    a_o = {a_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// WIDTH iterations per operation, single-cycle divide-by-zero path.
module divu_seq
  import divu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DzQuot = WIDTH'(dz_fill(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_p, step_a;

  divu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i(p_q),
    .a_i(a_q),
    .d_i(d_q),
    .p_o(step_p),
    .a_o(step_a)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q    <= '0;
      a_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      a_q    <= a_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (b != '0) ? StRun : StDz;
      StRun:   if (cnt_q == CNT_W'(1)) state_d = StIdle;
      StDz:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    p_d    = p_q;
    a_d    = a_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Dividend is captured on both paths; DZ reports it as the remainder.
          a_d = a;
          if (b != '0) begin
            p_d   = '0;
            d_d   = b;
            cnt_d = CNT_W'(WIDTH);
          end
        end
      end
      StRun: begin
        p_d   = step_p;
        a_d   = step_a;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          q_d    = step_a;
          r_d    = step_p;
          dz_d   = 1'b0;
          done_d = 1'b1;
        end
      end
      StDz: begin
        q_d    = DzQuot;
        r_d    = a_q;
        dz_d   = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = done_q;
    q           = q_q;
    r           = r_q;
    div_by_zero = dz_q;
  end

endmodule
